// File: rtl/ntt_io_pkg.sv
// Shared types and default geometry for the NTT stream gearbox.
// Exposes word_t, BEATS, FRAME_BEATS and vec_lane_slice().
package ntt_io_pkg;

    localparam int W_DEF     = 28;
    localparam int IPC_DEF   = 64;
    localparam int LANES_DEF = 4;
    localparam int VPF_DEF   = 32;
    localparam int DEPTH_DEF = 4;

    localparam int BEATS       = IPC_DEF / LANES_DEF;
    localparam int FRAME_BEATS = BEATS * VPF_DEF;

    typedef logic [W_DEF-1:0]           word_t;
    typedef logic [IPC_DEF*W_DEF-1:0]   vec_t;
    typedef logic [LANES_DEF*W_DEF-1:0] beat_t;

    function automatic beat_t vec_lane_slice(
        input vec_t        v,
        input int unsigned idx
    );
        return v[idx*LANES_DEF*W_DEF +: LANES_DEF*W_DEF];
    endfunction

endpackage

// File: rtl/ntt_vec_fifo.sv
// Vector FIFO with full/empty, same-cycle push+pop while full, drop flag.
// Ports: push/push_data in; pop in; head/full/empty/drop out.
module ntt_vec_fifo
    import ntt_io_pkg::*;
#(
    parameter int WIDTH = IPC_DEF * W_DEF + 1,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full buffer still accepts when the head leaves this cycle.
    assign do_push = push && (!full || do_pop);
    assign drop    = push && !do_push;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/ntt_stream_gearbox.sv
// Streaming gearbox: LANES-word beats <-> INPUT_PER_CYCLE-word core vectors.
// Ports: s_* ingress stream, core_in_* / core_out_* core side,
// m_* egress stream, overflow_err / framing_err sticky faults.
module ntt_stream_gearbox
    import ntt_io_pkg::*;
#(
    parameter int DATA_WIDTH_PER_INPUT = W_DEF,
    parameter int INPUT_PER_CYCLE      = IPC_DEF,
    parameter int LANES                = LANES_DEF,
    parameter int VECS_PER_FRAME       = VPF_DEF,
    parameter int OUT_DEPTH            = DEPTH_DEF
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        s_valid,
    output logic                                        s_ready,
    input  logic [LANES*DATA_WIDTH_PER_INPUT-1:0]       s_data,
    input  logic                                        s_last,
    output logic                                        core_in_valid,
    output logic                                        core_in_start,
    output logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_in_data,
    input  logic                                        core_out_valid,
    input  logic                                        core_out_start,
    input  logic [INPUT_PER_CYCLE*DATA_WIDTH_PER_INPUT-1:0] core_out_data,
    output logic                                        m_valid,
    input  logic                                        m_ready,
    output logic [LANES*DATA_WIDTH_PER_INPUT-1:0]       m_data,
    output logic                                        m_first,
    output logic                                        m_last,
    output logic                                        overflow_err,
    output logic                                        framing_err
);

    localparam int W   = DATA_WIDTH_PER_INPUT;
    localparam int BW  = LANES * W;
    localparam int VW  = INPUT_PER_CYCLE * W;
    localparam int NB  = INPUT_PER_CYCLE / LANES;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam int VCW = (VECS_PER_FRAME > 1) ? $clog2(VECS_PER_FRAME) : 1;

    logic [BCW-1:0] beat_cnt;
    logic [VCW-1:0] vec_cnt;
    logic [VW-1:0]  vec_q;
    logic           civ_q;
    logic           cis_q;
    logic           ferr_q;
    logic           oerr_q;
    logic           acc;
    logic           beat_end;
    logic           frame_end;

    logic [VW:0]    head;
    logic [VW-1:0]  head_vec;
    logic           head_start;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_drop;
    logic           xfer;
    logic           pop;
    logic [BCW-1:0] obeat;
    logic [VCW-1:0] ovec_q;
    logic [VCW-1:0] ovec_eff;
    logic           obeat_end;

    // Ingress never stalls: the core takes a vector every cycle.
    assign s_ready   = rst_n;
    assign acc       = s_valid && s_ready;
    assign beat_end  = (beat_cnt == BCW'(NB - 1));
    assign frame_end = beat_end && (vec_cnt == VCW'(VECS_PER_FRAME - 1));

    // The assembly register doubles as core_in_data: the pulse cycle
    // is the one right after the last slot is written.
    assign core_in_valid = civ_q;
    assign core_in_start = cis_q;
    assign core_in_data  = vec_q;
    assign framing_err   = ferr_q;
    assign overflow_err  = oerr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
            vec_cnt  <= '0;
            vec_q    <= '0;
            civ_q    <= 1'b0;
            cis_q    <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            civ_q <= 1'b0;
            cis_q <= 1'b0;
            if (acc) begin
                if (s_last && !frame_end) begin
                    // Early end: discard the partial vector, resync.
                    ferr_q   <= 1'b1;
                    beat_cnt <= '0;
                    vec_cnt  <= '0;
                end else begin
                    vec_q[32'(beat_cnt)*BW +: BW] <= s_data;
                    if (frame_end && !s_last) begin
                        ferr_q <= 1'b1;
                    end
                    if (beat_end) begin
                        civ_q    <= 1'b1;
                        cis_q    <= (vec_cnt == '0);
                        beat_cnt <= '0;
                        vec_cnt  <= (vec_cnt == VCW'(VECS_PER_FRAME - 1))
                                    ? '0 : vec_cnt + 1'b1;
                    end else begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
            end
        end
    end

    ntt_vec_fifo #(
        .WIDTH (VW + 1),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (core_out_valid),
        .push_data ({core_out_data, core_out_start}),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .drop      (fifo_drop)
    );

    assign head_vec   = head[VW:1];
    assign head_start = head[0];
    assign m_valid    = !fifo_empty;
    assign xfer       = m_valid && m_ready;
    assign obeat_end  = (obeat == BCW'(NB - 1));
    assign pop        = xfer && obeat_end;
    // A start vector restarts the egress frame count at zero.
    assign ovec_eff   = head_start ? '0 : ovec_q;

    assign m_data  = head_vec[32'(obeat)*BW +: BW];
    assign m_first = m_valid && head_start && (obeat == '0);
    assign m_last  = m_valid && obeat_end
                     && (ovec_eff == VCW'(VECS_PER_FRAME - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            obeat  <= '0;
            ovec_q <= '0;
            oerr_q <= 1'b0;
        end else begin
            if (xfer) begin
                if (obeat_end) begin
                    obeat  <= '0;
                    ovec_q <= (ovec_eff == VCW'(VECS_PER_FRAME - 1))
                              ? '0 : ovec_eff + 1'b1;
                end else begin
                    obeat <= obeat + 1'b1;
                end
            end
            if (fifo_drop) begin
                oerr_q <= 1'b1;
            end
        end
    end

endmodule
